// File: rtl/interval_timer.sv
// interval_timer: countdown timer serving the traffic-light controller.
// Holds base / extended / yellow second-counts and produces a one-cycle
// registered expiry pulse, a one-per-second tick while counting and the
// seconds remaining. Contains its own seconds divider.
//
// Handshake: none of the inputs use valid/ready. reprogramInp is a plain
// per-cycle write strobe, and enableTimer is a level that only gates the
// reload after an expiry. Every output is a flop; no input reaches an
// output combinationally.
module interval_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 4,
   parameter int BASE_DEF = 6,
   parameter int EXT_DEF  = 3,
   parameter int YEL_DEF  = 2
) (
   input  logic             clk,
   input  logic             globalReset,
   input  logic             enableTimer,
   input  logic [1:0]       intervalSel,
   input  logic             reprogramInp,
   input  logic [1:0]       timeParamSel,
   input  logic [CNT_W-1:0] timeValue,
   output logic             expired,
   output logic             oneHzTick,
   output logic [CNT_W-1:0] remaining,
   output logic [1:0]       dbg_state_o
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_EXPIRE = 2'd2,
      ST_IDLE   = 2'd3
   } state_t;

   state_t           state_q;
   logic             startup_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] remaining_q;
   logic             expired_q;
   logic             tick_q;
   logic [CNT_W-1:0] base_q;
   logic [CNT_W-1:0] ext_q;
   logic [CNT_W-1:0] yel_q;

   logic [CNT_W-1:0] sel_raw_d;
   logic [CNT_W-1:0] load_val_d;

   // Interval chosen by intervalSel (11 falls back to base); a zero
   // interval is coerced to one second so the count always terminates.
   always_comb begin
      sel_raw_d = base_q;
      case (intervalSel)
         2'b01:   sel_raw_d = ext_q;
         2'b10:   sel_raw_d = yel_q;
         default: sel_raw_d = base_q;
      endcase
      load_val_d = (sel_raw_d == '0) ? CNT_W'(1) : sel_raw_d;
   end

   // Timer FSM, divider, interval registers and registered outputs.
   always_ff @(posedge clk) begin
      if (globalReset) begin
         state_q     <= ST_LOAD;
         startup_q   <= 1'b1;
         div_q       <= '0;
         remaining_q <= '0;
         expired_q   <= 1'b0;
         tick_q      <= 1'b0;
         base_q      <= CNT_W'(BASE_DEF);
         ext_q       <= CNT_W'(EXT_DEF);
         yel_q       <= CNT_W'(YEL_DEF);
      end else if (reprogramInp) begin
         // A reprogram also throws away the running countdown and restarts
         // as if from power-up, matching the controller's own restart.
         case (timeParamSel)
            2'b00:   base_q <= timeValue;
            2'b01:   ext_q  <= timeValue;
            2'b10:   yel_q  <= timeValue;
            default: ;
         endcase
         state_q   <= ST_LOAD;
         startup_q <= 1'b1;
         div_q     <= '0;
         expired_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         expired_q <= 1'b0;
         tick_q    <= 1'b0;
         case (state_q)
            ST_LOAD: begin
               remaining_q <= load_val_d;
               div_q       <= '0;
               state_q     <= ST_COUNT;
            end
            ST_COUNT: begin
               if (div_q == DIV_W'(TICK_DIV - 1)) begin
                  div_q       <= '0;
                  tick_q      <= 1'b1;
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_q   <= ST_EXPIRE;
                     expired_q <= 1'b1;
                  end
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end
            ST_EXPIRE: begin
               startup_q <= 1'b0;
               state_q   <= enableTimer ? ST_LOAD : ST_IDLE;
            end
            ST_IDLE: begin
               if (enableTimer || startup_q) state_q <= ST_LOAD;
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   assign expired     = expired_q;
   assign oneHzTick   = tick_q;
   assign remaining   = remaining_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer with TICK_DIV = 4.
module tb_interval_timer;

  localparam int TICK  = 4;
  localparam int CNT_W = 4;
  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_EXPIRE = 2'd2;
  localparam logic [1:0] S_IDLE   = 2'd3;

  logic             clk;
  logic             globalReset;
  logic             enableTimer;
  logic [1:0]       intervalSel;
  logic             reprogramInp;
  logic [1:0]       timeParamSel;
  logic [CNT_W-1:0] timeValue;
  logic             expired;
  logic             oneHzTick;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       dbg_state;

  int tests_run;
  int tests_failed;
  logic [5:0] exp_q[$];

  interval_timer #(
    .TICK_DIV(TICK), .CNT_W(CNT_W), .BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2)
  ) dut (
    .clk(clk), .globalReset(globalReset), .enableTimer(enableTimer),
    .intervalSel(intervalSel), .reprogramInp(reprogramInp),
    .timeParamSel(timeParamSel), .timeValue(timeValue),
    .expired(expired), .oneHzTick(oneHzTick), .remaining(remaining),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT to be in its LOAD cycle at the current sample point,
  // then checks every cycle of an n-second interval up to the expire cycle.
  task automatic run_interval(input int n, input string tag);
    logic [5:0] e;
    logic [5:0] got;
    int k;
    tests_run++;
    if (dbg_state !== S_LOAD) begin
      tests_failed++;
      $display("FAIL %s load_state: got %0d want %0d", tag, dbg_state, S_LOAD);
    end
    for (int c = 1; c <= n * TICK + 1; c++) begin
      logic exp_e, exp_t;
      logic [CNT_W-1:0] exp_r;
      exp_e = (c == n * TICK + 1);
      exp_t = (c > 1) && (((c - 1) % TICK) == 0);
      exp_r = CNT_W'(n - (c - 1) / TICK);
      exp_q.push_back({exp_e, exp_t, exp_r});
    end
    k = 0;
    while (exp_q.size() > 0) begin
      step();
      k++;
      e = exp_q.pop_front();
      got = {expired, oneHzTick, remaining};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got exp/tick/rem=%b/%b/%0d want %b/%b/%0d",
                 tag, k, got[5], got[4], got[3:0], e[5], e[4], e[3:0]);
      end
    end
    tests_run++;
    if (dbg_state !== S_EXPIRE) begin
      tests_failed++;
      $display("FAIL %s expire_state: got %0d want %0d", tag, dbg_state, S_EXPIRE);
    end
  endtask

  task automatic test_reset();
    globalReset = 1'b1;
    repeat (3) step();
    globalReset = 1'b0;
    tests_run++;
    if ({dbg_state, expired, oneHzTick, remaining} !== {S_LOAD, 1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got st=%0d e=%b t=%b r=%0d want st=0 e=0 t=0 r=0",
               dbg_state, expired, oneHzTick, remaining);
    end
    tests_run++;
    if ({dut.base_q, dut.ext_q, dut.yel_q, dut.startup_q} !== {4'd6, 4'd3, 4'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_regs: got %0d/%0d/%0d su=%b want 6/3/2 su=1",
               dut.base_q, dut.ext_q, dut.yel_q, dut.startup_q);
    end
    // Startup interval runs without enableTimer, then parks in IDLE.
    run_interval(6, "startup_base");
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({dbg_state, expired, remaining} !== {S_IDLE, 1'b0, 4'd0}) begin
        tests_failed++;
        $display("FAIL idle_after_startup: got st=%0d e=%b r=%0d want st=3 e=0 r=0",
                 dbg_state, expired, remaining);
      end
    end
  endtask

  task automatic test_enable_extended();
    enableTimer = 1'b1;
    intervalSel = 2'b01;
    step();
    run_interval(3, "enable_ext");
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels[3];
    int lens[3];
    sels = '{2'b00, 2'b01, 2'b10};
    lens = '{6, 3, 2};
    for (int i = 0; i < 3; i++) begin
      intervalSel = sels[i];
      step();
      tests_run++;
      if (expired !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_pulse_width: got %b want 0", expired);
      end
      run_interval(lens[i], "back_to_back");
    end
    enableTimer = 1'b0;
    step();
    tests_run++;
    if (dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL b2b_idle: got %0d want %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_reprogram_zero();
    enableTimer = 1'b1;
    intervalSel = 2'b00;
    step();
    repeat (6) step();
    reprogramInp = 1'b1;
    timeParamSel = 2'b00;
    timeValue    = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({dbg_state, expired, dut.base_q} !== {S_LOAD, 1'b0, 4'd0}) begin
        tests_failed++;
        $display("FAIL reprog_hold: got st=%0d e=%b base=%0d want st=0 e=0 base=0",
                 dbg_state, expired, dut.base_q);
      end
    end
    reprogramInp = 1'b0;
    run_interval(1, "reprog_zero_coerced");
  endtask

  task automatic test_reset_midcount();
    intervalSel = 2'b01;
    step();
    enableTimer = 1'b0;
    repeat (5) step();
    tests_run++;
    if ({dbg_state, remaining} !== {S_COUNT, 4'd2}) begin
      tests_failed++;
      $display("FAIL midcount_setup: got st=%0d r=%0d want st=1 r=2", dbg_state, remaining);
    end
    globalReset = 1'b1;
    step();
    globalReset = 1'b0;
    tests_run++;
    if ({dbg_state, expired, remaining, dut.base_q, dut.ext_q, dut.yel_q} !==
        {S_LOAD, 1'b0, 4'd0, 4'd6, 4'd3, 4'd2}) begin
      tests_failed++;
      $display("FAIL midcount_reset: got st=%0d e=%b r=%0d regs=%0d/%0d/%0d want st=0 e=0 r=0 regs=6/3/2",
               dbg_state, expired, remaining, dut.base_q, dut.ext_q, dut.yel_q);
    end
    run_interval(3, "after_midcount_reset");
  endtask

  task automatic test_sel11();
    logic [CNT_W-1:0] v;
    intervalSel = 2'b11;
    enableTimer = 1'b1;
    step();
    run_interval(6, "sel11_base");
    enableTimer = 1'b0;
    intervalSel = 2'b01;
    step();
    enableTimer = 1'b1;
    step();
    enableTimer = 1'b0;
    repeat (3) step();
    reprogramInp = 1'b1;
    timeParamSel = 2'b11;
    timeValue    = CNT_W'($urandom_range(1, 15));
    step();
    reprogramInp = 1'b0;
    tests_run++;
    if ({dbg_state, dut.base_q, dut.ext_q, dut.yel_q} !== {S_LOAD, 4'd6, 4'd3, 4'd2}) begin
      tests_failed++;
      $display("FAIL psel11_nowrite: got st=%0d regs=%0d/%0d/%0d want st=0 regs=6/3/2",
               dbg_state, dut.base_q, dut.ext_q, dut.yel_q);
    end
    run_interval(3, "psel11_restart");
    // Random extended value written and used by the restart.
    v = CNT_W'($urandom_range(1, 5));
    reprogramInp = 1'b1;
    timeParamSel = 2'b01;
    timeValue    = v;
    step();
    reprogramInp = 1'b0;
    tests_run++;
    if (dut.ext_q !== v) begin
      tests_failed++;
      $display("FAIL reprog_ext: got %0d want %0d", dut.ext_q, v);
    end
    run_interval(int'(v), "reprog_ext_run");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    globalReset  = 1'b1;
    enableTimer  = 1'b0;
    intervalSel  = 2'b00;
    reprogramInp = 1'b0;
    timeParamSel = 2'b11;
    timeValue    = '0;
    test_reset();
    test_enable_extended();
    test_back_to_back();
    test_reprogram_zero();
    test_reset_midcount();
    test_sel11();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
